// File: rtl/dc_tag_req_ctrl_if.sv
// Core-side and bank-side handshake bundle for the data-cache tag request controller.
// The slave modport is the controller; the master modport is the core plus both tag banks.
interface dc_tag_req_ctrl_if #(
  parameter int unsigned Width   = 24,
  parameter int unsigned ReqBits = 7
);
  logic               core_req_valid;
  logic               core_req_retry;
  logic [Width-1:0]   core_req_data;
  logic [ReqBits-1:0] core_req_type;
  logic               core_req_write;

  logic [Width-1:0]   tag_req_data;
  logic [ReqBits-1:0] tag_req_type;
  logic               tag_req_write;
  logic [2:0]         tag_req_id;
  logic               even_req_valid;
  logic               odd_req_valid;
  logic               even_req_retry;
  logic               odd_req_retry;

  logic               even_ack_valid;
  logic               odd_ack_valid;
  logic               even_ack_retry;
  logic               odd_ack_retry;
  logic [2:0]         even_ack_req;
  logic [2:0]         odd_ack_req;
  logic               even_hit;
  logic               even_miss;
  logic               odd_hit;
  logic               odd_miss;
  logic [2:0]         even_way;
  logic [2:0]         odd_way;

  logic               core_ack_valid;
  logic               core_ack_retry;
  logic               core_ack_hit;
  logic               core_ack_miss;
  logic [2:0]         core_ack_way;
  logic [ReqBits-1:0] core_ack_type;
  logic               core_ack_odd;
  logic               protocol_err;

  modport slave (
    input  core_req_valid, core_req_data, core_req_type, core_req_write,
    output core_req_retry,
    output tag_req_data, tag_req_type, tag_req_write, tag_req_id,
    output even_req_valid, odd_req_valid,
    input  even_req_retry, odd_req_retry,
    input  even_ack_valid, odd_ack_valid, even_ack_req, odd_ack_req,
    input  even_hit, even_miss, odd_hit, odd_miss, even_way, odd_way,
    output even_ack_retry, odd_ack_retry,
    output core_ack_valid, core_ack_hit, core_ack_miss, core_ack_way, core_ack_type,
    output core_ack_odd, protocol_err,
    input  core_ack_retry
  );

  modport master (
    output core_req_valid, core_req_data, core_req_type, core_req_write,
    input  core_req_retry,
    input  tag_req_data, tag_req_type, tag_req_write, tag_req_id,
    input  even_req_valid, odd_req_valid,
    output even_req_retry, odd_req_retry,
    output even_ack_valid, odd_ack_valid, even_ack_req, odd_ack_req,
    output even_hit, even_miss, odd_hit, odd_miss, even_way, odd_way,
    input  even_ack_retry, odd_ack_retry,
    input  core_ack_valid, core_ack_hit, core_ack_miss, core_ack_way, core_ack_type,
    input  core_ack_odd, protocol_err,
    output core_ack_retry
  );
endinterface

// File: rtl/dc_tag_req_ctrl.sv
// Steers core tag lookups to the even/odd bank by index bit and returns bank results
// to the core in issue order through an 8-entry reorder buffer.
module dc_tag_req_ctrl #(
  parameter int unsigned Width   = 24,
  parameter int unsigned ReqBits = 7,
  parameter int unsigned IdxBit  = 10
) (
  input logic              i_clk,
  input logic              i_rst_n,
  dc_tag_req_ctrl_if.slave io_bus
);
  localparam int unsigned Depth = 8;

  // Issue stage
  logic               r_iss_valid, w_iss_valid_d;
  logic [Width-1:0]   r_iss_data, w_iss_data_d;
  logic [ReqBits-1:0] r_iss_type, w_iss_type_d;
  logic               r_iss_write, w_iss_write_d;
  logic [2:0]         r_iss_id, w_iss_id_d;

  // Reorder buffer bookkeeping
  logic [3:0]         r_count, w_count_d;
  logic [2:0]         r_alloc_ptr, w_alloc_ptr_d;
  logic [2:0]         r_ret_ptr, w_ret_ptr_d;
  logic [Depth-1:0]   r_done, w_done_d;
  logic [Depth-1:0]   r_hit, w_hit_d;
  logic [Depth-1:0]   r_miss, w_miss_d;
  logic [Depth-1:0]   r_odd, w_odd_d;
  logic [2:0]         r_way [Depth];
  logic [2:0]         w_way_d [Depth];
  logic [ReqBits-1:0] r_type [Depth];
  logic [ReqBits-1:0] w_type_d [Depth];
  logic               r_err, w_err_d;

  logic       w_iss_odd, w_sel_retry, w_stall, w_req_retry, w_accept;
  logic       w_ack_valid, w_retire;
  logic [2:0] w_even_off, w_odd_off;
  logic       w_even_err, w_odd_err;

  assign w_iss_odd   = r_iss_data[IdxBit];
  assign w_sel_retry = w_iss_odd ? io_bus.odd_req_retry : io_bus.even_req_retry;
  assign w_stall     = r_iss_valid & w_sel_retry;
  assign w_req_retry = (r_count == 4'd8) | w_stall;
  assign w_accept    = io_bus.core_req_valid & ~w_req_retry;
  assign w_ack_valid = r_done[r_ret_ptr] & (r_count != 4'd0);
  assign w_retire    = w_ack_valid & ~io_bus.core_ack_retry;

  // An ID is outstanding when its distance from ret_ptr is below count.
  assign w_even_off = io_bus.even_ack_req - r_ret_ptr;
  assign w_odd_off  = io_bus.odd_ack_req - r_ret_ptr;
  assign w_even_err = io_bus.even_ack_valid & (({1'b0, w_even_off} >= r_count) |
                      r_done[io_bus.even_ack_req] | r_odd[io_bus.even_ack_req] |
                      (io_bus.even_hit == io_bus.even_miss));
  assign w_odd_err  = io_bus.odd_ack_valid & (({1'b0, w_odd_off} >= r_count) |
                      r_done[io_bus.odd_ack_req] | ~r_odd[io_bus.odd_ack_req] |
                      (io_bus.odd_hit == io_bus.odd_miss));

  always_comb begin
    w_iss_valid_d = r_iss_valid;
    w_iss_data_d  = r_iss_data;
    w_iss_type_d  = r_iss_type;
    w_iss_write_d = r_iss_write;
    w_iss_id_d    = r_iss_id;
    w_alloc_ptr_d = r_alloc_ptr;
    w_ret_ptr_d   = r_ret_ptr;
    w_count_d     = r_count + {3'b000, w_accept} - {3'b000, w_retire};
    w_done_d      = r_done;
    w_hit_d       = r_hit;
    w_miss_d      = r_miss;
    w_odd_d       = r_odd;
    w_way_d       = r_way;
    w_type_d      = r_type;
    w_err_d       = r_err | w_even_err | w_odd_err;

    if (w_accept) begin
      w_iss_valid_d          = 1'b1;
      w_iss_data_d           = io_bus.core_req_data;
      w_iss_type_d           = io_bus.core_req_type;
      w_iss_write_d          = io_bus.core_req_write;
      w_iss_id_d             = r_alloc_ptr;
      w_alloc_ptr_d          = r_alloc_ptr + 3'd1;
      w_done_d[r_alloc_ptr]  = 1'b0;
      w_type_d[r_alloc_ptr]  = io_bus.core_req_type;
      w_odd_d[r_alloc_ptr]   = io_bus.core_req_data[IdxBit];
    end else if (!w_stall) begin
      w_iss_valid_d = 1'b0;
    end

    if (w_retire) begin
      w_ret_ptr_d          = r_ret_ptr + 3'd1;
      w_done_d[r_ret_ptr]  = 1'b0;
    end

    // Bank acks are applied last; data is captured even when the ack is erroneous.
    if (io_bus.even_ack_valid) begin
      w_done_d[io_bus.even_ack_req] = 1'b1;
      w_hit_d[io_bus.even_ack_req]  = io_bus.even_hit;
      w_miss_d[io_bus.even_ack_req] = io_bus.even_miss;
      w_way_d[io_bus.even_ack_req]  = io_bus.even_way;
    end
    if (io_bus.odd_ack_valid) begin
      w_done_d[io_bus.odd_ack_req] = 1'b1;
      w_hit_d[io_bus.odd_ack_req]  = io_bus.odd_hit;
      w_miss_d[io_bus.odd_ack_req] = io_bus.odd_miss;
      w_way_d[io_bus.odd_ack_req]  = io_bus.odd_way;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_data  <= '0;
      r_iss_type  <= '0;
      r_iss_write <= 1'b0;
      r_iss_id    <= '0;
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      r_count     <= '0;
      r_done      <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_odd       <= '0;
      r_way       <= '{default: '0};
      r_type      <= '{default: '0};
      r_err       <= 1'b0;
    end else begin
      r_iss_valid <= w_iss_valid_d;
      r_iss_data  <= w_iss_data_d;
      r_iss_type  <= w_iss_type_d;
      r_iss_write <= w_iss_write_d;
      r_iss_id    <= w_iss_id_d;
      r_alloc_ptr <= w_alloc_ptr_d;
      r_ret_ptr   <= w_ret_ptr_d;
      r_count     <= w_count_d;
      r_done      <= w_done_d;
      r_hit       <= w_hit_d;
      r_miss      <= w_miss_d;
      r_odd       <= w_odd_d;
      r_way       <= w_way_d;
      r_type      <= w_type_d;
      r_err       <= w_err_d;
    end
  end

  assign io_bus.core_req_retry = w_req_retry;
  assign io_bus.tag_req_data   = r_iss_valid ? r_iss_data : '0;
  assign io_bus.tag_req_type   = r_iss_valid ? r_iss_type : '0;
  assign io_bus.tag_req_write  = r_iss_valid & r_iss_write;
  assign io_bus.tag_req_id     = r_iss_valid ? r_iss_id : '0;
  assign io_bus.even_req_valid = r_iss_valid & ~w_iss_odd;
  assign io_bus.odd_req_valid  = r_iss_valid & w_iss_odd;
  assign io_bus.even_ack_retry = 1'b0;
  assign io_bus.odd_ack_retry  = 1'b0;
  assign io_bus.core_ack_valid = w_ack_valid;
  assign io_bus.core_ack_hit   = r_hit[r_ret_ptr];
  assign io_bus.core_ack_miss  = r_miss[r_ret_ptr];
  assign io_bus.core_ack_way   = r_way[r_ret_ptr];
  assign io_bus.core_ack_type  = r_type[r_ret_ptr];
  assign io_bus.core_ack_odd   = r_odd[r_ret_ptr];
  assign io_bus.protocol_err   = r_err;
endmodule

// File: tb/tb_dc_tag_req_ctrl.sv
// Randomised and directed bench for dc_tag_req_ctrl; an in-order result queue plus
// per-bank pending lists predict every output each cycle.
module tb_dc_tag_req_ctrl;
  localparam int unsigned Width   = 24;
  localparam int unsigned ReqBits = 7;
  localparam int unsigned IdxBit  = 10;

  logic clk;
  logic rst_n;

  dc_tag_req_ctrl_if #(.Width(Width), .ReqBits(ReqBits)) bus ();

  dc_tag_req_ctrl #(.Width(Width), .ReqBits(ReqBits), .IdxBit(IdxBit)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]         id;
    logic [ReqBits-1:0] typ;
    bit                 odd;
    bit                 done;
    bit                 hit;
    bit                 miss;
    logic [2:0]         way;
  } rec_t;

  rec_t               rob[$];
  int                 even_pend[$];
  int                 odd_pend[$];
  bit                 iss_v;
  logic [Width-1:0]   iss_data;
  logic [ReqBits-1:0] iss_type;
  bit                 iss_write;
  logic [2:0]         iss_id;
  logic [2:0]         next_id;
  bit                 err;
  int                 n_vec;
  int                 n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.core_req_valid = 1'b0;
    bus.core_req_data  = '0;
    bus.core_req_type  = '0;
    bus.core_req_write = 1'b0;
    bus.even_req_retry = 1'b0;
    bus.odd_req_retry  = 1'b0;
    bus.even_ack_valid = 1'b0;
    bus.odd_ack_valid  = 1'b0;
    bus.even_ack_req   = '0;
    bus.odd_ack_req    = '0;
    bus.even_hit       = 1'b0;
    bus.even_miss      = 1'b0;
    bus.odd_hit        = 1'b0;
    bus.odd_miss       = 1'b0;
    bus.even_way       = '0;
    bus.odd_way        = '0;
    bus.core_ack_retry = 1'b0;
  endtask

  task automatic model_reset();
    rob.delete();
    even_pend.delete();
    odd_pend.delete();
    iss_v   = 1'b0;
    next_id = 3'd0;
    err     = 1'b0;
  endtask

  task automatic apply_ack(input bit bank_odd, input logic [2:0] id, input bit hit,
                           input bit miss, input logic [2:0] way);
    int   k;
    int   p;
    rec_t r;
    k = -1;
    p = -1;
    foreach (rob[i]) if (rob[i].id == id) k = i;
    if (bank_odd) begin
      foreach (odd_pend[i]) if (odd_pend[i] == int'(id)) p = i;
      if (p >= 0) odd_pend.delete(p);
    end else begin
      foreach (even_pend[i]) if (even_pend[i] == int'(id)) p = i;
      if (p >= 0) even_pend.delete(p);
    end
    if (k < 0) err = 1'b1;
    else begin
      r = rob[k];
      if (r.done || (r.odd != bank_odd) || (hit == miss)) err = 1'b1;
      r.done = 1'b1;
      r.hit  = hit;
      r.miss = miss;
      r.way  = way;
      rob[k] = r;
    end
  endtask

  // One clock cycle: inputs are already driven; compare, advance the model, cross the edge.
  task automatic step();
    bit   sel_retry;
    bit   exp_retry;
    bit   exp_av;
    bit   iss_odd;
    rec_t n;
    #1;
    iss_odd   = iss_data[IdxBit];
    sel_retry = iss_odd ? bus.odd_req_retry : bus.even_req_retry;
    exp_retry = (rob.size() == 8) || (iss_v && sel_retry);
    exp_av    = (rob.size() > 0) && rob[0].done;

    chk("even_req_valid", 64'(bus.even_req_valid), 64'(iss_v && !iss_odd));
    chk("odd_req_valid", 64'(bus.odd_req_valid), 64'(iss_v && iss_odd));
    chk("tag_req_data", 64'(bus.tag_req_data), 64'(iss_v ? iss_data : '0));
    chk("tag_req_type", 64'(bus.tag_req_type), 64'(iss_v ? iss_type : '0));
    chk("tag_req_write", 64'(bus.tag_req_write), 64'(iss_v && iss_write));
    chk("tag_req_id", 64'(bus.tag_req_id), 64'(iss_v ? iss_id : 3'd0));
    chk("core_req_retry", 64'(bus.core_req_retry), 64'(exp_retry));
    chk("core_ack_valid", 64'(bus.core_ack_valid), 64'(exp_av));
    chk("ack_retry", 64'({bus.even_ack_retry, bus.odd_ack_retry}), 64'(0));
    chk("protocol_err", 64'(bus.protocol_err), 64'(err));
    if (exp_av) begin
      chk("core_ack_result",
          64'({bus.core_ack_hit, bus.core_ack_miss, bus.core_ack_way, bus.core_ack_odd}),
          64'({rob[0].hit, rob[0].miss, rob[0].way, rob[0].odd}));
      chk("core_ack_type", 64'(bus.core_ack_type), 64'(rob[0].typ));
    end

    if (iss_v && !sel_retry) begin
      if (iss_odd) odd_pend.push_back(int'(iss_id));
      else         even_pend.push_back(int'(iss_id));
    end
    if (bus.even_ack_valid)
      apply_ack(1'b0, bus.even_ack_req, bus.even_hit, bus.even_miss, bus.even_way);
    if (bus.odd_ack_valid)
      apply_ack(1'b1, bus.odd_ack_req, bus.odd_hit, bus.odd_miss, bus.odd_way);
    if (exp_av && !bus.core_ack_retry) void'(rob.pop_front());
    if (bus.core_req_valid && !exp_retry) begin
      n.id   = next_id;
      n.typ  = bus.core_req_type;
      n.odd  = bus.core_req_data[IdxBit];
      n.done = 1'b0;
      n.hit  = 1'b0;
      n.miss = 1'b0;
      n.way  = 3'd0;
      rob.push_back(n);
      iss_v     = 1'b1;
      iss_data  = bus.core_req_data;
      iss_type  = bus.core_req_type;
      iss_write = bus.core_req_write;
      iss_id    = next_id;
      next_id   = next_id + 3'd1;
    end else if (!(iss_v && sel_retry)) begin
      iss_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst valids", 64'({bus.even_req_valid, bus.odd_req_valid, bus.core_ack_valid,
                           bus.core_req_retry, bus.protocol_err}), 64'(0));
    chk("rst tag_req", 64'({bus.tag_req_data, bus.tag_req_type, bus.tag_req_write,
                            bus.tag_req_id}), 64'(0));
    chk("rst core_ack data", 64'({bus.core_ack_hit, bus.core_ack_miss, bus.core_ack_way,
                                  bus.core_ack_type, bus.core_ack_odd}), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle();
    int k;
    clr();
    bus.core_req_valid = $urandom_range(0, 9) < 7;
    bus.core_req_data  = Width'($urandom);
    bus.core_req_type  = ReqBits'($urandom);
    bus.core_req_write = 1'($urandom);
    bus.even_req_retry = $urandom_range(0, 3) == 0;
    bus.odd_req_retry  = $urandom_range(0, 3) == 0;
    bus.core_ack_retry = $urandom_range(0, 3) == 0;
    if (even_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = int'($urandom_range(0, even_pend.size() - 1));
      bus.even_ack_valid = 1'b1;
      bus.even_ack_req   = 3'(even_pend[k]);
      bus.even_hit       = 1'($urandom);
      bus.even_miss      = ~bus.even_hit;
      bus.even_way       = 3'($urandom);
    end
    if (odd_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = int'($urandom_range(0, odd_pend.size() - 1));
      bus.odd_ack_valid = 1'b1;
      bus.odd_ack_req   = 3'(odd_pend[k]);
      bus.odd_hit       = 1'($urandom);
      bus.odd_miss      = ~bus.odd_hit;
      bus.odd_way       = 3'($urandom);
    end
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    clr();
    model_reset();
    #2;
    do_reset();

    // Single even request, hit way 5
    clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'd3; step();
    chk("d1 even_req_valid", 64'(bus.even_req_valid), 64'(1));
    chk("d1 tag_req_id", 64'(bus.tag_req_id), 64'(0));
    clr(); step();
    clr(); bus.even_ack_valid = 1'b1; bus.even_ack_req = 3'd0; bus.even_hit = 1'b1;
    bus.even_way = 3'd5; step();
    chk("d1 core_ack_valid", 64'(bus.core_ack_valid), 64'(1));
    chk("d1 hit/miss/way/odd", 64'({bus.core_ack_hit, bus.core_ack_miss, bus.core_ack_way,
                                    bus.core_ack_odd}), 64'(6'b101010));
    clr(); step();
    chk("d1 retired", 64'(bus.core_ack_valid), 64'(0));

    // Odd then even; even acks first but must wait
    clr(); bus.core_req_valid = 1'b1; bus.core_req_data = 24'h000400; bus.core_req_type = 7'd1;
    step();
    clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'd2; step();
    clr(); step();
    clr(); bus.even_ack_valid = 1'b1; bus.even_ack_req = 3'd2; bus.even_hit = 1'b1;
    bus.even_way = 3'd3; step();
    chk("d2 even held", 64'(bus.core_ack_valid), 64'(0));
    clr(); step();
    clr(); bus.odd_ack_valid = 1'b1; bus.odd_ack_req = 3'd1; bus.odd_miss = 1'b1; step();
    chk("d2 odd first", 64'({bus.core_ack_valid, bus.core_ack_odd, bus.core_ack_miss}),
        64'(3'b111));
    clr(); step();
    chk("d2 even next", 64'({bus.core_ack_valid, bus.core_ack_odd, bus.core_ack_hit,
                             bus.core_ack_way}), 64'(6'b101011));
    clr(); step();

    // Fill all 8 entries, then retire id 0 and see the allocation pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'(i); step();
    end
    chk("d3 full retry", 64'(bus.core_req_retry), 64'(1));
    clr(); bus.core_req_valid = 1'b1; bus.even_ack_valid = 1'b1; bus.even_ack_req = 3'd0;
    bus.even_hit = 1'b1; bus.even_way = 3'd1; step();
    chk("d3 still full", 64'({bus.core_req_retry, bus.core_ack_valid}), 64'(2'b11));
    clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'd9; step();
    chk("d3 retry drops", 64'(bus.core_req_retry), 64'(0));
    clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'd9; step();
    chk("d3 id wrap", 64'({bus.even_req_valid, bus.tag_req_id}), 64'(4'b1000));

    // Odd bank backpressure for 3 cycles, then a back-to-back stream
    do_reset();
    clr(); bus.core_req_valid = 1'b1; bus.core_req_data = 24'h000400; bus.core_req_type = 7'd4;
    step();
    for (int i = 0; i < 3; i++) begin
      clr(); bus.core_req_valid = 1'b1; bus.core_req_data = 24'h000401; bus.odd_req_retry = 1'b1;
      step();
      chk("d4 hold retry", 64'(bus.core_req_retry), 64'(1));
      chk("d4 hold data", 64'({bus.odd_req_valid, bus.tag_req_data}), 64'(25'h1000400));
    end
    for (int i = 0; i < 6; i++) begin
      clr(); bus.core_req_valid = 1'b1; bus.core_req_data = 24'(i * 1024 + i);
      bus.core_req_type = 7'(i + 16); step();
    end

    for (int c = 0; c < 3000; c++) rand_cycle();

    // Reset mid-stream, then a fresh request must get id 0
    do_reset();
    clr(); bus.core_req_valid = 1'b1; bus.core_req_type = 7'd5; step();
    chk("d6 fresh id", 64'({bus.even_req_valid, bus.tag_req_id}), 64'(4'b1000));

    // Protocol errors: unknown id, then hit==miss
    do_reset();
    clr(); bus.even_ack_valid = 1'b1; bus.even_ack_req = 3'd5; bus.even_hit = 1'b1; step();
    chk("d5 err unknown id", 64'(bus.protocol_err), 64'(1));
    for (int i = 0; i < 3; i++) begin
      clr(); step();
    end
    chk("d5 err sticky", 64'(bus.protocol_err), 64'(1));
    do_reset();
    clr(); bus.core_req_valid = 1'b1; step();
    clr(); step();
    clr(); bus.even_ack_valid = 1'b1; bus.even_ack_req = 3'd0; bus.even_hit = 1'b1;
    bus.even_miss = 1'b1; step();
    chk("d5 err hit==miss", 64'(bus.protocol_err), 64'(1));
    clr(); bus.core_ack_retry = 1'b1; step();
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
